// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset main controller.
// Moore FSM: every datapath select/enable is decoded from the state register.
// The only input-dependent outputs are alu_ctrl in EXECUTE (decoded from
// funct) and pc_en (depends on zero). illegal_op and instr_done are
// registered one-cycle pulses that appear in the FETCH cycle that follows
// the instruction they describe.
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_ctrl,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  state_t next_state;
  logic   pc_write;
  logic   pc_write_cond;
  logic   illegal_d;
  logic   done_d;

  // State register and the two registered status pulses.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      illegal_op <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      state_q    <= next_state;
      illegal_op <= illegal_d;
      instr_done <= done_d;
    end
  end

  // Next-state logic and Moore output decode.
  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned; an unassigned path in always_comb infers a latch.
  always_comb begin
    next_state    = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_ctrl      = 3'b000;
    illegal_d     = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b01;
        alu_ctrl   = ALU_ADD;
        next_state = DECODE;
      end
      DECODE: begin
        // Speculatively compute the branch target while decoding.
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default: begin
            next_state = FETCH;
            illegal_d  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_ctrl   = ALU_ADD;
        next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = FETCH;
        done_d     = 1'b1;
      end
      MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        next_state = FETCH;
        done_d     = 1'b1;
      end
      EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b00;
        next_state = ALUWB;
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: begin
            alu_ctrl   = ALU_ADD;
            illegal_d  = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = FETCH;
        done_d     = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b00;
        alu_ctrl      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        next_state    = FETCH;
        done_d        = 1'b1;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_ctrl   = ALU_ADD;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        next_state = FETCH;
        done_d     = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        next_state = FETCH;
        done_d     = 1'b1;
      end
      // Unused encodings 12-15 recover to FETCH without retiring anything.
      default: next_state = FETCH;
    endcase
  end

  assign pc_en = pc_write | (pc_write_cond & zero);
  assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Randomized scoreboard bench for mc_control. A driver issues whole
// instructions and pushes the per-cycle expected observation (state,
// control vector, status pulses) into a queue; a negedge monitor pops and
// compares one entry per clock.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic       illegal_op, instr_done;

  mc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .alu_ctrl   (alu_ctrl),
    .state      (state),
    .illegal_op (illegal_op),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  typedef enum int {K_LW, K_SW, K_R, K_RBAD, K_BEQ, K_ADDI, K_J, K_BADOP} kind_t;
  typedef enum int {END_NONE, END_DONE, END_ILLEGAL} end_t;

  // Control vector order:
  // {pc_en,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
  //  alu_src_a,alu_src_b[1:0],pc_source[1:0],alu_ctrl[2:0]}
  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ill;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle_no = 0;
  bit   mon_en = 1'b0;
  end_t prev_end = END_NONE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU code an R-type funct should select; unknown functs fall back to ADD.
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit funct_known(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic bit opcode_known(input logic [5:0] op);
    return op inside {6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b100011, 6'b101011};
  endfunction

  // Expected control vector for a given step of the instruction table.
  function automatic logic [15:0] exp_ctrl(input int st, input logic z, input logic [2:0] ex_alu);
    logic pe, iod, mr, mw, irw, rd, m2r, rw, sa;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {pe, iod, mr, mw, irw, rd, m2r, rw, sa} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b000;
    case (st)
      0:  begin pe = 1; mr = 1; irw = 1; sb = 2'b01; alu = 3'b010; end
      1:  begin sb = 2'b11; alu = 3'b010; end
      2:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin sa = 1; alu = ex_alu; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; alu = 3'b110; ps = 2'b01; pe = z; end
      9:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
      10: begin rw = 1; end
      11: begin pe = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pe, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ps, alu};
  endfunction

  // Issue one instruction starting in a FETCH cycle (called at posedge+1):
  // push the expected per-cycle trace, drive the fields, and hold them for
  // the instruction's full latency.
  task automatic issue(input kind_t k, input logic [5:0] op, input logic [5:0] fn, input logic z);
    int seq[$];
    exp_t e;
    case (k)
      K_LW:    seq = '{0, 1, 2, 3, 4};
      K_SW:    seq = '{0, 1, 2, 5};
      K_R:     seq = '{0, 1, 6, 7};
      K_RBAD:  seq = '{0, 1, 6};
      K_BEQ:   seq = '{0, 1, 8};
      K_ADDI:  seq = '{0, 1, 9, 10};
      K_J:     seq = '{0, 1, 11};
      default: seq = '{0, 1};
    endcase
    foreach (seq[i]) begin
      e.st   = 4'(seq[i]);
      e.ctrl = exp_ctrl(seq[i], z, funct_alu(fn));
      e.ill  = (i == 0) && (prev_end == END_ILLEGAL);
      e.done = (i == 0) && (prev_end == END_DONE);
      q.push_back(e);
    end
    prev_end = (k == K_RBAD || k == K_BADOP) ? END_ILLEGAL : END_DONE;
    opcode = op;
    funct  = fn;
    zero   = z;
    repeat (seq.size()) @(posedge clk);
    #1;
  endtask

  task automatic issue_random();
    kind_t k;
    logic [5:0] op, fn;
    k  = kind_t'($urandom_range(0, 7));
    fn = 6'($urandom);
    case (k)
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_ADDI: op = 6'b001000;
      K_J:    op = 6'b000010;
      K_R: begin
        op = 6'b000000;
        case ($urandom_range(0, 4))
          0: fn = 6'b100000;
          1: fn = 6'b100010;
          2: fn = 6'b100100;
          3: fn = 6'b100101;
          default: fn = 6'b101010;
        endcase
      end
      K_RBAD: begin
        op = 6'b000000;
        while (funct_known(fn)) fn = 6'($urandom);
      end
      default: begin
        op = 6'($urandom);
        while (opcode_known(op)) op = 6'($urandom);
      end
    endcase
    issue(k, op, fn, 1'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("scoreboard_drain", 32'(q.size()), 32'd0);
  endtask

  // Monitor: compares one expected entry per clock, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && q.size() != 0) begin
      e = q.pop_front();
      cycle_no++;
      check($sformatf("state@%0d", cycle_no), 32'(state), 32'(e.st));
      check($sformatf("ctrl@%0d_st%0d", cycle_no, e.st),
            32'({pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl}), 32'(e.ctrl));
      check($sformatf("ill_done@%0d", cycle_no), 32'({illegal_op, instr_done}),
            32'({e.ill, e.done}));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_pulses", 32'({illegal_op, instr_done}), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed sequence: lw, slt, beq taken/not-taken, bad opcode, j then sw.
    issue(K_LW,    6'b100011, 6'h00,     1'b0);
    issue(K_R,     6'b000000, 6'b101010, 1'b0);
    issue(K_BEQ,   6'b000100, 6'h15,     1'b1);
    issue(K_BEQ,   6'b000100, 6'h15,     1'b0);
    issue(K_BADOP, 6'b111111, 6'h00,     1'b0);
    issue(K_J,     6'b000010, 6'h00,     1'b0);
    issue(K_SW,    6'b101011, 6'h00,     1'b0);
    issue(K_RBAD,  6'b000000, 6'b000001, 1'b0);
    issue(K_ADDI,  6'b001000, 6'h00,     1'b0);

    for (int i = 0; i < 200; i++) issue_random();
    drain();
    mon_en = 1'b0;

    // Reset clears a pending illegal_op pulse asynchronously.
    opcode = 6'b111111;
    repeat (2) @(posedge clk);
    #1;
    check("illegal_pulse_before_reset", 32'({state, illegal_op}), 32'({4'd0, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("illegal_cleared_by_reset", 32'({illegal_op, instr_done}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset during MEMWR aborts the store before the next edge.
    opcode = 6'b101011;
    repeat (3) @(posedge clk);
    #2;
    check("memwr_reached", 32'({state, mem_write}), 32'({4'd5, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("memwr_abort", 32'({state, mem_write}), 32'({4'd0, 1'b0}));
    check("memwr_abort_pulses", 32'({illegal_op, instr_done}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    prev_end = END_NONE;
    mon_en = 1'b1;

    // After deassertion the first edge must leave FETCH for DECODE.
    for (int i = 0; i < 40; i++) issue_random();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 opcode  in  6  instruction bits [31:26], valid from the DECODE state onward.
REQ-004 funct  in  6  instruction bits [5:0], used only when opcode=000000.
REQ-005 zero  in  1  ALU zero flag, sampled in the BRANCH state.
REQ-006 pc_en  out  1  PC load enable = pc_write | (pc_write_cond & zero).
REQ-007 i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  out  1 each  datapath selects and enables.
REQ-008 alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
REQ-009 pc_source  out  2  00 ALU result, 01 ALU-out register, 10 jump target.
REQ-010 alu_ctrl  out  3  ALU op code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-011 state  out  4  current state encoding, for debug.
REQ-012 illegal_op  out  1  one-cycle registered pulse on an unknown opcode or funct.
REQ-013 instr_done  out  1  one-cycle registered pulse when an instruction retires.

Function
REQ-014 States SHALL be encoded as follows: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; encodings 12-15 go to FETCH on the next edge.
REQ-015 FETCH SHALL assert mem_read, ir_write, pc_write, alu_src_b=01 and alu_ctrl=010, with i_or_d=0 and pc_source=00, and SHALL always go to DECODE.
REQ-016 DECODE SHALL drive alu_src_b=11 and alu_ctrl=010 (branch target), and SHALL branch on opcode:
- 100011 or 101011 -> MEMADR
- 000000 -> EXECUTE
- 000100 -> BRANCH
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other opcode -> FETCH with illegal_op pulsed.
REQ-017 MEMADR SHALL drive alu_src_a=1, alu_src_b=10 and alu_ctrl=010, then go to MEMRD if opcode=100011, else to MEMWR.
REQ-018 MEMRD SHALL drive mem_read=1 and i_or_d=1, then go to MEMWB.
REQ-019 MEMWB SHALL drive reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-020 MEMWR SHALL drive mem_write=1 and i_or_d=1, then go to FETCH.
REQ-021 EXECUTE SHALL drive alu_src_a=1 and alu_src_b=00, with alu_ctrl mapped from funct:
- 100000 -> 010
- 100010 -> 110
- 100100 -> 000
- 100101 -> 001
- 101010 -> 111
- any other funct -> alu_ctrl=010, illegal_op pulsed, next state FETCH.
Otherwise EXECUTE SHALL go to ALUWB.
REQ-022 ALUWB SHALL drive reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-023 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_write_cond=1 and pc_source=01, then go to FETCH.
REQ-024 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10 and alu_ctrl=010, then go to ADDIWB; ADDIWB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-025 JUMP SHALL drive pc_write=1 and pc_source=10, then go to FETCH.
REQ-026 Datapath outputs SHALL be pure Moore decodes of the state register, with no dependence on inputs except alu_ctrl in EXECUTE and pc_en via zero; every unlisted control SHALL be 0 and every unlisted select SHALL be 00.
REQ-027 instr_done SHALL pulse in the cycle after any state that transitions to FETCH, but not after an illegal_op exit.
REQ-028 Instruction latencies SHALL be:
- lw 5 cycles
- sw, R-type and addi 4 cycles
- beq and j 3 cycles
- illegal opcode 2 cycles
- illegal funct 3 cycles.

Reset
REQ-029 While rst_n=0, state SHALL be FETCH and illegal_op=instr_done=0, asynchronously and independent of clk.
REQ-030 Reset asserted mid-instruction SHALL abort the instruction without completing any write-enable cycle; the first rising edge after deassertion SHALL leave FETCH for DECODE.

Verification
REQ-031 Reset then opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_done pulses once.
REQ-032 opcode=000000, funct=101010 -> EXECUTE drives alu_ctrl=111; ALUWB drives reg_dst=1; 4 cycles total.
REQ-033 opcode=000100 with zero=1, then zero=0 -> pc_en=1 in BRANCH for the first case, 0 for the second; pc_source=01 in both.
REQ-034 opcode=111111 -> DECODE->FETCH; illegal_op pulses one cycle; instr_done stays 0.
REQ-035 rst_n driven low during MEMWR (state 5) -> state=0 immediately and mem_write=0 before the next clk edge.
REQ-036 Back-to-back j then sw -> states 0,1,11,0,1,2,5,0; pc_en=1 in FETCH and JUMP only.
